// File: rtl/o3_pkg.sv
// Shared out-of-order core types: load-buffer entry state/struct, memory access sizes,
// and the doubleword byte-extract helper also used by store-to-load forwarding.
package o3_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DWLEN = 64;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        LB_FREE = 2'd0,
        LB_WAIT = 2'd1,
        LB_MEM  = 2'd2,
        LB_DONE = 2'd3
    } lb_state_e;

    typedef struct packed {
        lb_state_e        state;
        logic [XLEN-1:0]  addr;
        mem_size_e        size;
        logic             sgn;
        logic [XLEN-1:0]  value;
    } lb_entry_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] mem_size_bytes(input mem_size_e size);
        case (size)
            MEM_BYTE: return 4'd1;
            MEM_HALF: return 4'd2;
            default:  return 4'd4;
        endcase
    endfunction

    // Select the addressed bytes of a little-endian doubleword and extend to XLEN.
    function automatic logic [XLEN-1:0] load_extract(input logic [DWLEN-1:0] dw,
                                                     input logic [2:0]       off,
                                                     input mem_size_e        size,
                                                     input logic             sgn);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = XLEN'(dw >> {off, 3'b000});
        case (size)
            MEM_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
            MEM_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
            default:  res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_buffer_if.sv
// Load-buffer bus: ACU allocation, hazard handshake, D-memory read port and CDB result.
interface load_buffer_if #(
    parameter int unsigned ROB_IDX_W = 5
);
    logic                 squash;
    logic                 alloc_valid;
    logic [31:0]          alloc_addr;
    logic [1:0]           alloc_size;
    logic                 alloc_signed;
    logic [ROB_IDX_W-1:0] alloc_rob_idx;
    logic                 lb_exec_stall;
    logic                 commit_wr_mem;
    logic [63:0]          mem_rd_data;
    logic                 lb_wr_enable;

    logic                 ex_rd_mem;
    logic [31:0]          ex_rd_addr;
    logic                 lb_full;
    logic                 lb_cdb_valid;
    logic [ROB_IDX_W-1:0] lb_cdb_rob_idx;
    logic [31:0]          lb_cdb_value;

    modport master (
        output squash, alloc_valid, alloc_addr, alloc_size, alloc_signed, alloc_rob_idx,
               lb_exec_stall, commit_wr_mem, mem_rd_data, lb_wr_enable,
        input  ex_rd_mem, ex_rd_addr, lb_full, lb_cdb_valid, lb_cdb_rob_idx, lb_cdb_value
    );

    modport slave (
        input  squash, alloc_valid, alloc_addr, alloc_size, alloc_signed, alloc_rob_idx,
               lb_exec_stall, commit_wr_mem, mem_rd_data, lb_wr_enable,
        output ex_rd_mem, ex_rd_addr, lb_full, lb_cdb_valid, lb_cdb_rob_idx, lb_cdb_value
    );
endinterface

// File: rtl/load_buffer_select.sv
// Pick one entry from an eligible mask: lowest index, or oldest age stamp when
// LB_AGE_ORDER_EN is defined (modulo compare, MSB of the difference marks "older").
module lb_select #(
    parameter int unsigned N  = 4
`ifdef LB_AGE_ORDER_EN
   ,parameter int unsigned AW = $clog2(N) + 1
`endif
) (
    input  logic [N-1:0]         mask,
`ifdef LB_AGE_ORDER_EN
    input  logic [AW-1:0]        ages [N],
`endif
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int unsigned IW = $clog2(N);

`ifdef LB_AGE_ORDER_EN
    logic [AW-1:0] best_age;
    logic [AW-1:0] diff;

    always_comb begin
        idx      = '0;
        valid    = 1'b0;
        best_age = '0;
        diff     = '0;
        for (int i = 0; i < N; i++) begin
            diff = ages[i] - best_age;
            if (mask[i] && (!valid || diff[AW-1])) begin
                idx      = IW'(i);
                valid    = 1'b1;
                best_age = ages[i];
            end
        end
    end
`else
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/load_buffer.sv
// Load buffer: holds resolved loads, issues one D-memory read at a time, returns results on the CDB.
// Optional LB_AGE_ORDER_EN: oldest-first issue/CDB selection using per-entry age stamps.
module load_buffer
    import o3_pkg::*;
#(
    parameter int unsigned LB_SIZE   = 4,
    parameter int unsigned ROB_IDX_W = 5
) (
    input logic         clock,
    input logic         reset,
    load_buffer_if.slave bus
);
    localparam int unsigned IW = $clog2(LB_SIZE);

    lb_entry_t            entries_q [LB_SIZE];
    lb_entry_t            entries_d [LB_SIZE];
    logic [ROB_IDX_W-1:0] rob_q     [LB_SIZE];
    logic [ROB_IDX_W-1:0] rob_d     [LB_SIZE];
    logic                 drop_resp_q, drop_resp_d;

`ifdef LB_AGE_ORDER_EN
    localparam int unsigned AW = IW + 1;
    logic [AW-1:0] age_q [LB_SIZE];
    logic [AW-1:0] age_d [LB_SIZE];
    logic [AW-1:0] alloc_cnt_q, alloc_cnt_d;
`endif

    logic [LB_SIZE-1:0] free_mask, wait_mask, mem_mask, done_mask;
    logic [IW-1:0]      alloc_idx, issue_idx, cdb_idx;
    logic               issue_any, cdb_any, issue, do_alloc;

    always_comb begin
        free_mask = '0;
        wait_mask = '0;
        mem_mask  = '0;
        done_mask = '0;
        for (int i = 0; i < LB_SIZE; i++) begin
            free_mask[i] = (entries_q[i].state == LB_FREE);
            wait_mask[i] = (entries_q[i].state == LB_WAIT);
            mem_mask[i]  = (entries_q[i].state == LB_MEM);
            done_mask[i] = (entries_q[i].state == LB_DONE);
        end
    end

    // Allocation always fills the lowest-index FREE entry.
    always_comb begin
        alloc_idx = '0;
        for (int i = LB_SIZE - 1; i >= 0; i--) begin
            if (free_mask[i]) alloc_idx = IW'(i);
        end
    end

    lb_select #(.N(LB_SIZE)) u_issue_sel (
        .mask  (wait_mask),
`ifdef LB_AGE_ORDER_EN
        .ages  (age_q),
`endif
        .idx   (issue_idx),
        .valid (issue_any)
    );

    lb_select #(.N(LB_SIZE)) u_cdb_sel (
        .mask  (done_mask),
`ifdef LB_AGE_ORDER_EN
        .ages  (age_q),
`endif
        .idx   (cdb_idx),
        .valid (cdb_any)
    );

    assign issue    = issue_any && !bus.lb_exec_stall && !bus.commit_wr_mem && !(|mem_mask) && !reset;
    assign do_alloc = bus.alloc_valid && !bus.lb_full && !bus.squash;

    assign bus.ex_rd_mem      = issue;
    assign bus.ex_rd_addr     = issue ? {entries_q[issue_idx].addr[31:3], 3'b000} : 32'h0;
    assign bus.lb_full        = ~|free_mask;
    assign bus.lb_cdb_valid   = cdb_any;
    assign bus.lb_cdb_rob_idx = cdb_any ? rob_q[cdb_idx] : '0;
    assign bus.lb_cdb_value   = cdb_any ? entries_q[cdb_idx].value : 32'h0;

    // Per-entry next state: return, issue, CDB free, alloc; squash overrides all.
    always_comb begin
        entries_d   = entries_q;
        rob_d       = rob_q;
        drop_resp_d = 1'b0;
`ifdef LB_AGE_ORDER_EN
        age_d       = age_q;
        alloc_cnt_d = alloc_cnt_q;
`endif
        for (int i = 0; i < LB_SIZE; i++) begin
            if (entries_q[i].state == LB_MEM && !drop_resp_q) begin
                entries_d[i].value = load_extract(bus.mem_rd_data, entries_q[i].addr[2:0],
                                                  entries_q[i].size, entries_q[i].sgn);
                entries_d[i].state = LB_DONE;
            end
        end
        if (issue) entries_d[issue_idx].state = LB_MEM;
        if (cdb_any && bus.lb_wr_enable) entries_d[cdb_idx].state = LB_FREE;
        if (do_alloc) begin
            entries_d[alloc_idx] = '{state: LB_WAIT, addr: bus.alloc_addr,
                                     size: mem_size_e'(bus.alloc_size),
                                     sgn: bus.alloc_signed, value: 32'h0};
            rob_d[alloc_idx]     = bus.alloc_rob_idx;
`ifdef LB_AGE_ORDER_EN
            age_d[alloc_idx]     = alloc_cnt_q;
            alloc_cnt_d          = alloc_cnt_q + AW'(1);
`endif
        end
        if (bus.squash) begin
            for (int i = 0; i < LB_SIZE; i++) entries_d[i].state = LB_FREE;
            drop_resp_d = issue;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LB_SIZE; i++) begin
                entries_q[i] <= '0;
                rob_q[i]     <= '0;
`ifdef LB_AGE_ORDER_EN
                age_q[i]     <= '0;
`endif
            end
            drop_resp_q <= 1'b0;
`ifdef LB_AGE_ORDER_EN
            alloc_cnt_q <= '0;
`endif
        end else begin
            entries_q   <= entries_d;
            rob_q       <= rob_d;
            drop_resp_q <= drop_resp_d;
`ifdef LB_AGE_ORDER_EN
            age_q       <= age_d;
            alloc_cnt_q <= alloc_cnt_d;
`endif
        end
    end

    // Protocol checks: no alloc while full, no access crossing a doubleword.
    always_ff @(posedge clock) begin
        if (!reset && bus.alloc_valid) begin
            assert (!bus.lb_full)
                else $error("load_buffer: alloc while lb_full, load dropped");
            assert ((4'({1'b0, bus.alloc_addr[2:0]}) + mem_size_bytes(mem_size_e'(bus.alloc_size))) <= 4'd8)
                else $error("load_buffer: misaligned access crosses doubleword");
        end
    end

endmodule
